// File: rtl/accum_stim_driver.sv
// Buffers accumulate commands and drives enable/value to the accumulator, tracking a shadow sum.
// Define ACCUM_CHECK_EN to compare the consumer's led against the shadow sum (sticky mismatch).

module accum_stim_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_dat,
  output logic [WIDTH-1:0]         o_dat,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign w_push  = i_push && (r_level != LW'(DEPTH));
  assign w_pop   = i_pop && (r_level != '0);
  assign o_dat   = r_mem[r_rptr];
  assign o_level = r_level;

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= i_dat;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

module accum_stim_driver #(
  parameter int DEPTH    = 4,
  parameter int WIDTH    = 32,
  parameter int IDLE_GAP = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     cmd_valid,
  input  logic [WIDTH-1:0]         cmd_value,
  output logic                     cmd_ready,
  output logic                     enable,
  output logic [WIDTH-1:0]         value,
  input  logic [7:0]               led,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              issued_count,
  output logic [WIDTH-1:0]         expected_sum,
  output logic                     mismatch
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [3:0] GAP_LAST = 4'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_W1, S_W2, S_GAP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_value;
  logic [WIDTH-1:0] r_sum;
  logic [15:0]      r_issued;
  logic [3:0]       r_gap_cnt;
  logic             w_pop;
  logic             w_fifo_ne;
  logic [WIDTH-1:0] w_head;
  logic [LW-1:0]    w_level;

  accum_stim_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (cmd_valid && cmd_ready),
    .i_pop   (w_pop),
    .i_dat   (cmd_value),
    .o_dat   (w_head),
    .o_level (w_level)
  );

  assign w_fifo_ne    = (w_level != '0);
  assign cmd_ready    = (w_level != LW'(DEPTH));
  assign enable       = (r_state == S_REQ);
  assign value        = r_value;
  assign busy         = (r_state != S_IDLE) || w_fifo_ne;
  assign fifo_level   = w_level;
  assign issued_count = r_issued;
  assign expected_sum = r_sum;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_ne) begin
          w_pop       = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: w_state_nxt = S_W1;
      S_W1:  w_state_nxt = S_W2;
      S_W2: begin
        // Without a gap the next head is popped here so REQ follows W2 directly.
        if (IDLE_GAP != 0) begin
          w_state_nxt = S_GAP;
        end else if (w_fifo_ne) begin
          w_pop       = 1'b1;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_value   <= '0;
      r_sum     <= '0;
      r_issued  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) r_value <= w_head;
      if (r_state == S_W2) begin
        r_sum    <= r_sum + r_value;
        r_issued <= r_issued + 16'd1;
      end
      if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 4'd1;
      else                  r_gap_cnt <= '0;
    end
  end

`ifdef ACCUM_CHECK_EN
  logic r_chk_pend;
  logic r_mismatch;

  // led reflects the consumer's count one cycle after the W2 closing edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chk_pend <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_chk_pend <= (r_state == S_W2);
      if (r_chk_pend && (led != r_sum[23:16])) r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused_led;
  assign w_unused_led = ^led;
  assign mismatch     = 1'b0;
`endif
endmodule

// File: tb/tb_accum_stim_driver.sv
// Directed bench for accum_stim_driver with a behavioural model of the accumulating consumer.
module tb_accum_stim_driver;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_value = '0;
  logic        cmd_ready;
  logic        enable;
  logic [31:0] value;
  logic [7:0]  led;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [15:0] issued_count;
  logic [31:0] expected_sum;
  logic        mismatch;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ACCUM_CHECK_EN
  localparam logic EXP_MM = 1'b1;
`else
  localparam logic EXP_MM = 1'b0;
`endif

  accum_stim_driver #(.DEPTH(4), .WIDTH(32), .IDLE_GAP(0)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .cmd_valid    (cmd_valid),
    .cmd_value    (cmd_value),
    .cmd_ready    (cmd_ready),
    .enable       (enable),
    .value        (value),
    .led          (led),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .issued_count (issued_count),
    .expected_sum (expected_sum),
    .mismatch     (mismatch)
  );

  always #5 CLK = ~CLK;

  // Consumer: idle samples enable, waits a cycle, then adds value.
  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_ADD} cst_t;
  cst_t        c_state;
  logic [31:0] c_cnt;
  logic        led_force = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      c_state <= C_IDLE;
      c_cnt   <= '0;
    end else begin
      case (c_state)
        C_IDLE:  if (enable) c_state <= C_WAIT;
        C_WAIT:  c_state <= C_ADD;
        default: begin
          c_cnt   <= c_cnt + value;
          c_state <= C_IDLE;
        end
      endcase
    end
  end

  assign led = led_force ? 8'h55 : c_cnt[23:16];

  // Pulse spacing and occupancy monitor, cleared by reset.
  int cyc = 0;
  int last_en = 0;
  int en_count = 0;
  int bad_gap = 0;
  int peak = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST) begin
      en_count <= 0;
      bad_gap  <= 0;
      peak     <= 0;
    end else begin
      if (enable) begin
        en_count <= en_count + 1;
        if (en_count != 0 && (cyc - last_en) != 3) bad_gap <= bad_gap + 1;
        last_en <= cyc;
      end
      if (int'(fifo_level) > peak) peak <= int'(fifo_level);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    cmd_valid = 1'b0;
    led_force = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic push(input logic [31:0] v);
    cmd_valid = 1'b1;
    cmd_value = v;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_pulses(input string name, input int n);
    int k = 0;
    while (en_count < n && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check(name, 32'(en_count >= n), 32'd1);
  endtask

  typedef struct {
    logic [31:0] val;
    logic [31:0] sum;
    logic [15:0] cnt;
    logic [7:0]  led;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0001_0000, 32'h0001_0000, 16'd1, 8'h01};
    vecs[1] = '{32'h0000_0000, 32'h0001_0000, 16'd2, 8'h01};
    vecs[2] = '{32'h00FE_0000, 32'h00FF_0000, 16'd3, 8'hFF};
    vecs[3] = '{32'h0001_0000, 32'h0100_0000, 16'd4, 8'h00};
    vecs[4] = '{32'h1234_5678, 32'h1334_5678, 16'd5, 8'h34};
    vecs[5] = '{32'hEDCB_A988, 32'h0100_0000, 16'd6, 8'h00};

    @(negedge CLK);
    do_reset();
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_value", value, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_issued", 32'(issued_count), 32'd0);
    check("rst_sum", expected_sum, 32'd0);
    check("rst_mismatch", 32'(mismatch), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // Single command: latency, one-cycle enable, stable value.
    push(32'h0001_0000);
    check("t1_level_acc", 32'(fifo_level), 32'd1);
    check("t1_en_pre", 32'(enable), 32'd0);
    @(negedge CLK);
    check("t1_en_req", 32'(enable), 32'd1);
    check("t1_val_req", value, 32'h0001_0000);
    check("t1_level_pop", 32'(fifo_level), 32'd0);
    @(negedge CLK);
    check("t1_en_w1", 32'(enable), 32'd0);
    check("t1_val_w1", value, 32'h0001_0000);
    @(negedge CLK);
    check("t1_en_w2", 32'(enable), 32'd0);
    check("t1_val_w2", value, 32'h0001_0000);
    check("t1_busy_w2", 32'(busy), 32'd1);
    @(negedge CLK);
    check("t1_sum", expected_sum, 32'h0001_0000);
    check("t1_issued", 32'(issued_count), 32'd1);
    check("t1_led", 32'(led), 32'h01);
    check("t1_busy_done", 32'(busy), 32'd0);
    @(negedge CLK);
    check("t1_mismatch", 32'(mismatch), 32'd0);

    // Four back-to-back commands: pulses exactly 3 cycles apart.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_value = 32'h0000_8000;
      @(negedge CLK);
    end
    cmd_valid = 1'b0;
    wait_pulses("t2_pulses_wait", 4);
    @(negedge CLK);
    check("t2_busy_last_w2", 32'(busy), 32'd1);
    @(negedge CLK);
    check("t2_busy_after", 32'(busy), 32'd0);
    check("t2_sum", expected_sum, 32'h0002_0000);
    check("t2_issued", 32'(issued_count), 32'd4);
    check("t2_led", 32'(led), 32'h02);
    check("t2_pulses", 32'(en_count), 32'd4);
    check("t2_spacing", 32'(bad_gap), 32'd0);
    check("t2_peak", 32'(peak), 32'd3);

    // Overfill with cmd_valid held: pushes while full are dropped.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1;
      cmd_value = 32'(i + 1) << 16;
      @(negedge CLK);
      if (i == 5) begin
        check("t3_ready_full", 32'(cmd_ready), 32'd0);
        check("t3_level_full", 32'(fifo_level), 32'd4);
      end
      if (i == 6) check("t3_level_drop", 32'(fifo_level), 32'd4);
      if (i == 7) check("t3_level_drop_pop", 32'(fifo_level), 32'd3);
    end
    cmd_valid = 1'b0;
    wait_idle("t3_idle");
    check("t3_sum", expected_sum, 32'h0015_0000);
    check("t3_issued", 32'(issued_count), 32'd6);
    check("t3_led", 32'(led), 32'h15);
    check("t3_peak", 32'(peak), 32'd4);

    // Shadow sum wraps modulo 2^32.
    do_reset();
    push(32'hFFFF_FFFF);
    push(32'h0000_0002);
    wait_idle("t4_idle");
    check("t4_sum", expected_sum, 32'h0000_0001);
    check("t4_issued", 32'(issued_count), 32'd2);
    check("t4_led", 32'(led), 32'h00);

    // Reset during W1 aborts the transaction.
    do_reset();
    push(32'h00FF_0000);
    wait_pulses("t5_req_wait", 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("t5_enable", 32'(enable), 32'd0);
    check("t5_value", value, 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_level", 32'(fifo_level), 32'd0);
    check("t5_issued", 32'(issued_count), 32'd0);
    check("t5_sum", expected_sum, 32'd0);
    check("t5_ready", 32'(cmd_ready), 32'd1);
    push(32'h0001_0000);
    wait_idle("t5_idle");
    check("t5_sum_after", expected_sum, 32'h0001_0000);
    check("t5_led_after", 32'(led), 32'h01);

    // Table: cumulative single commands.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].val);
      wait_idle($sformatf("tv%0d_idle", i));
      check($sformatf("tv%0d_sum", i), expected_sum, vecs[i].sum);
      check($sformatf("tv%0d_issued", i), 32'(issued_count), 32'(vecs[i].cnt));
      check($sformatf("tv%0d_led", i), 32'(led), 32'(vecs[i].led));
    end

    // Corrupted led: sticky mismatch only when the check is built in.
    do_reset();
    push(32'h0001_0000);
    led_force = 1'b1;
    wait_idle("t7_idle");
    check("t7_mm_pre", 32'(mismatch), 32'd0);
    @(negedge CLK);
    check("t7_mm_set", 32'(mismatch), 32'(EXP_MM));
    repeat (3) @(negedge CLK);
    led_force = 1'b0;
    @(negedge CLK);
    check("t7_mm_sticky", 32'(mismatch), 32'(EXP_MM));
    do_reset();
    check("t7_mm_rst", 32'(mismatch), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
